// File: rtl/audio_sample_mem_resp.sv
// audio_sample_mem_resp: responder end of the audio mixer's sample-memory handshake.
// It holds the channel samples and the mix buffer in one synchronous RAM and serves
// one single-word read or write at a time through the stb/ack/cyc/stb_o sequence.
// Optional feature macro: AUDIO_SAMPLE_MEM_OOR_EN. When it is defined, an address at
// or above DEPTH is out of range and sets the sticky err_o flag. When it is not
// defined, addresses wrap modulo DEPTH.
module audio_sample_mem_resp #(
    parameter int unsigned DW      = 32,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned WR_BUSY = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stb_i,
    input  logic          sel_i,
    input  logic          we_i,
    input  logic [31:0]   addr_i,
    input  logic [DW-1:0] dat_o,
    output logic [DW-1:0] dat_i,
    output logic          ack_o,
    output logic          stb_o,
    output logic          cyc_o,
    output logic          err_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = 4;
    localparam int unsigned WR_CNT0 = WR_BUSY - 1;
    localparam int unsigned RD_CNT0 = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ACC,
        S_WR_BUSY,
        S_RD_WAIT,
        S_HOLD
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   idx_l;
    logic            we_l;
    logic [DW-1:0]   wdata_l;
    logic            oor_l;
    logic            oor_c;

    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   rd_data [RD_LAT];

    // The last read-pipeline stage is the held read-data register.
    assign dat_i = rd_data[RD_LAT-1];

`ifdef AUDIO_SAMPLE_MEM_OOR_EN
    // Any address bit above the RAM index means the access is out of range.
    assign oor_c = |addr_i[31:AW];

    // Sticky error flag: it sets when an out-of-range request reaches ACC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (state == S_ACC && oor_l) begin
            err_o <= 1'b1;
        end
    end
`else
    // The upper address bits are dropped, so addresses wrap modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:AW];
    assign oor_c          = 1'b0;
    assign err_o          = 1'b0;
`endif

    // Handshake FSM with registered ack/stb/cyc and the request latch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_INIT;
            ack_o   <= 1'b0;
            stb_o   <= 1'b0;
            cyc_o   <= 1'b0;
            cnt     <= '0;
            idx_l   <= '0;
            we_l    <= 1'b0;
            wdata_l <= '0;
            oor_l   <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    state <= S_IDLE;
                    ack_o <= 1'b1;
                end
                S_IDLE: begin
                    if (stb_i && sel_i) begin
                        state   <= S_ACC;
                        ack_o   <= 1'b0;
                        stb_o   <= 1'b1;
                        cyc_o   <= 1'b1;
                        idx_l   <= addr_i[AW-1:0];
                        we_l    <= we_i;
                        wdata_l <= dat_o;
                        oor_l   <= oor_c;
                    end
                end
                S_ACC: begin
                    stb_o <= 1'b0;
                    if (!we_l) begin
                        state <= S_WR_BUSY;
                        cnt   <= CW'(WR_CNT0);
                    end else if (RD_LAT == 1) begin
                        state <= S_HOLD;
                        cyc_o <= 1'b0;
                    end else begin
                        state <= S_RD_WAIT;
                        cnt   <= CW'(RD_CNT0);
                    end
                end
                S_WR_BUSY, S_RD_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_HOLD;
                        cyc_o <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    // Wait until the strobe is released so a held strobe is not accepted twice.
                    if (!stb_i) begin
                        state <= S_IDLE;
                        ack_o <= 1'b1;
                    end
                end
                default: begin
                    state <= S_INIT;
                    ack_o <= 1'b0;
                    stb_o <= 1'b0;
                    cyc_o <= 1'b0;
                end
            endcase
        end
    end

    // The RAM write commits in ACC. A reset in that same cycle drops the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == S_ACC && !we_l && !oor_l) begin
            mem[idx_l] <= wdata_l;
        end
    end

    // Read pipeline: the RAM is sampled in ACC, then each stage advances on its own cycle of RD_WAIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(RD_LAT); k++) begin
                rd_data[k] <= '0;
            end
        end else begin
            if (state == S_ACC && we_l) begin
                rd_data[0] <= oor_l ? '0 : mem[idx_l];
            end
            for (int k = 1; k < int'(RD_LAT); k++) begin
                if (state == S_RD_WAIT && cnt == CW'(RD_LAT - 1 - k)) begin
                    rd_data[k] <= rd_data[k-1];
                end
            end
        end
    end

endmodule
